// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared types for the RV32I multicycle control sequencer.
// State encoding, opcode constants and the one-hot instruction-type bundle.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic i;
    logic r;
    logic s;
    logic sb;
    logic u;
    logic uj;
  } itype_t;

endpackage

// File: rtl/rv_ctrl_if.sv
// rv_ctrl_if: instruction/data memory handshake between sequencer and memories.
// master = sequencer side, slave = memory side.
interface rv_ctrl_if;

  logic imem_req_o;
  logic imem_valid_i;
  logic dmem_req_o;
  logic dmem_we_o;
  logic dmem_ready_i;

  modport master (
    output imem_req_o,
    output dmem_req_o,
    output dmem_we_o,
    input  imem_valid_i,
    input  dmem_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  dmem_req_o,
    input  dmem_we_o,
    output imem_valid_i,
    output dmem_ready_i
  );

endinterface

// File: rtl/rv_instr_type_dec.sv
// rv_instr_type_dec: opcode -> one-hot instruction type plus side flags.
// Purely combinational; anything outside RV32I base opcodes is illegal.
module rv_instr_type_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output itype_t     o_type,
  output logic       o_illegal,
  output logic       o_load,
  output logic       o_jalr
);

  // Classify the opcode into exactly one type or flag it illegal
  always_comb begin
    o_type    = '0;
    o_illegal = 1'b0;
    o_load    = 1'b0;
    o_jalr    = 1'b0;
    unique case (1'b1)
      (i_opcode == OP_R):      o_type.r  = 1'b1;
      (i_opcode == OP_IMM):    o_type.i  = 1'b1;
      (i_opcode == OP_LOAD): begin
        o_type.i = 1'b1;
        o_load   = 1'b1;
      end
      (i_opcode == OP_JALR): begin
        o_type.i = 1'b1;
        o_jalr   = 1'b1;
      end
      (i_opcode == OP_STORE):  o_type.s  = 1'b1;
      (i_opcode == OP_BRANCH): o_type.sb = 1'b1;
      (i_opcode == OP_LUI):    o_type.u  = 1'b1;
      (i_opcode == OP_AUIPC):  o_type.u  = 1'b1;
      (i_opcode == OP_JAL):    o_type.uj = 1'b1;
      default:                 o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for RV32I.
// Optional performance counters are built when RV_PERF_CNT_EN is defined.
module rv_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic             branch_taken_i,
  rv_ctrl_if.master        mem_if,
  output logic             ir_we_o,
  output logic             I_EN_o,
  output logic             R_EN_o,
  output logic             S_EN_o,
  output logic             SB_EN_o,
  output logic             U_EN_o,
  output logic             UJ_EN_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             illegal_o,
`ifdef RV_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o,
`endif
  output logic [2:0]       state_o
);

  state_t      r_state;
  itype_t      r_type;
  logic        r_load;
  logic        r_jalr;
  logic        r_illegal;

  itype_t      w_type;
  logic        w_illegal;
  logic        w_load;
  logic        w_jalr;
  logic [24:0] w_instr_unused;

  logic        w_imem_req;
  logic        w_ir_we;
  logic        w_dmem_req;
  logic        w_dmem_we;
  logic        w_rf_we;
  logic        w_pc_we;
  logic        w_pc_sel;

  assign w_instr_unused = instr_i[31:7];

  rv_instr_type_dec u_dec (
    .i_opcode  (instr_i[6:0]),
    .o_type    (w_type),
    .o_illegal (w_illegal),
    .o_load    (w_load),
    .o_jalr    (w_jalr)
  );

  // State sequencing plus registered type enables and sticky illegal
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_type    <= '0;
      r_load    <= 1'b0;
      r_jalr    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_if.imem_valid_i)
            r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_type <= w_type;
          r_load <= w_load;
          r_jalr <= w_jalr;
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          r_state <= (r_load || r_type.s) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_if.dmem_ready_i)
            r_state <= r_load ? S_WB : S_FETCH;
        end
        S_WB:   r_state <= S_FETCH;
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and requests decoded from the current state
  always_comb begin
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_rf_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_we    = mem_if.imem_valid_i;
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = r_type.s;
        w_pc_we    = r_type.s & mem_if.dmem_ready_i;
      end
      S_WB: begin
        w_pc_we  = 1'b1;
        w_rf_we  = r_type.r | r_type.i
                 | r_type.u | r_type.uj;
        w_pc_sel = r_type.uj | r_jalr
                 | (r_type.sb & branch_taken_i);
      end
      default: ;
    endcase
  end

  assign mem_if.imem_req_o = w_imem_req;
  assign mem_if.dmem_req_o = w_dmem_req;
  assign mem_if.dmem_we_o  = w_dmem_we;

  assign ir_we_o   = w_ir_we;
  assign rf_we_o   = w_rf_we;
  assign pc_we_o   = w_pc_we;
  assign pc_sel_o  = w_pc_sel;
  assign illegal_o = r_illegal;
  assign state_o   = r_state;

  assign I_EN_o  = r_type.i;
  assign R_EN_o  = r_type.r;
  assign S_EN_o  = r_type.s;
  assign SB_EN_o = r_type.sb;
  assign U_EN_o  = r_type.u;
  assign UJ_EN_o = r_type.uj;

`ifdef RV_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret;

  // Cycle and retire counters, frozen once trapped
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else if (r_state != S_TRAP) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_pc_we)
        r_instret <= r_instret + 1'b1;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
  assign instret_o   = r_instret;
`else
  logic [CNT_W-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

endmodule
